// File: rtl/rr_decode_arbiter.sv
// Four-requester round-robin arbiter with registered 2-bit grant address and one-hot decoded grant.
// Optional forced revoke after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [1:0] grant_addr,
  output logic [3:0] grant,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] addr_reg, addr_next;
  logic       valid_reg, valid_next;
  logic [1:0] winner;
  logic       release_now;

  if (MAX_HOLD < 2 || MAX_HOLD > 15 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_check
    $error("rr_decode_arbiter: MAX_HOLD must be 2..15 and fit in CNT_W bits");
  end

  // First requester found scanning upward from the priority pointer.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    winner = ptr_reg;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_reg + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign release_now = done || !req[addr_reg];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    addr_next  = addr_reg;
    valid_next = valid_reg;
`ifdef ARB_TIMEOUT_EN
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (|req) begin
          addr_next  = winner;
          valid_next = 1'b1;
          state_next = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_now) begin
          valid_next = 1'b0;
          ptr_next   = addr_reg + 2'd1;
          state_next = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // A normal release on the final cycle wins, so timeout only fires here.
        else if (cnt_reg == CNT_W'(MAX_HOLD - 1)) begin
          valid_next   = 1'b0;
          ptr_next     = addr_reg + 2'd1;
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      addr_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  assign grant_valid = valid_reg;
  assign grant_addr  = addr_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_decode
    assign grant[gi] = valid_reg && (addr_reg == 2'(gi));
  end

endmodule
